// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//
// Raster timing source for the display path. Produces the pixel/line counters,
// horizontal and vertical sync pin levels, an active-video flag, a one-cycle
// end-of-frame tick and a slow blink square wave for the renderers.
//
// Ports:
//   clk          in   pixel clock (25.175 MHz nominal for 640x480@60)
//   rst_n        in   asynchronous active-low reset
//   pix_x        out  current column, 0..H_TOTAL-1
//   pix_y        out  current line,   0..V_TOTAL-1
//   hsync        out  horizontal sync pin level (SYNC_POL inside the pulse)
//   v_sync       out  vertical sync pin level, also the renderer frame clock
//   video_active out  high while (pix_x, pix_y) lies in the visible area
//   frame_tick   out  one-cycle pulse on the last pixel of each frame
//   blink_signal out  square wave, BLINK_FRAMES frames per half-period
//
// Every output is a flop. The decoded outputs are computed from the
// next-state counter values so that they line up with the pix_x/pix_y shown
// in the same cycle.
// -----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit SYNC_POL     = 1'b0,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       v_sync,
  output logic       video_active,
  output logic       frame_tick,
  output logic       blink_signal
);

  // ---------------------------------------------------------------------------
  // Derived timing constants
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  // Frame counter is at least one bit wide so BLINK_FRAMES = 1 still builds.
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [9:0]      H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]      V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  // ---------------------------------------------------------------------------
  // Parameter sanity: the 10-bit counters cannot represent a total above 1024.
  // ---------------------------------------------------------------------------
  generate
    if (H_TOTAL > 1024 || H_TOTAL < 1) begin : g_bad_h_total
      $error("vga_sync_gen: H_TOTAL must be in 1..1024");
    end
    if (V_TOTAL > 1024 || V_TOTAL < 1) begin : g_bad_v_total
      $error("vga_sync_gen: V_TOTAL must be in 1..1024");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
      $error("vga_sync_gen: BLINK_FRAMES must be >= 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [9:0]      r_x;
  logic [9:0]      r_y;
  logic            r_hsync;
  logic            r_vsync;
  logic            r_active;
  logic            r_frame_tick;
  logic            r_blink;
  logic [FC_W-1:0] r_frame_cnt;

  // ---------------------------------------------------------------------------
  // Next-state counters and decode
  // ---------------------------------------------------------------------------
  logic       w_x_last;
  logic       w_y_last;
  logic [9:0] w_x_next;
  logic [9:0] w_y_next;
  logic       w_hs_window;
  logic       w_vs_window;
  logic       w_active_next;
  logic       w_tick_next;

  always_comb begin
    w_x_last = (r_x == H_LAST);
    w_y_last = (r_y == V_LAST);

    // Wrap by compare so neither counter ever passes its total.
    w_x_next = w_x_last ? 10'd0 : (r_x + 10'd1);
    if (w_x_last) begin
      w_y_next = w_y_last ? 10'd0 : (r_y + 10'd1);
    end else begin
      w_y_next = r_y;
    end

    // Window bounds may equal 1024, so compare in 11 bits.
    w_hs_window   = ({1'b0, w_x_next} >= 11'(HS_START)) &&
                    ({1'b0, w_x_next} <  11'(HS_END));
    w_vs_window   = ({1'b0, w_y_next} >= 11'(VS_START)) &&
                    ({1'b0, w_y_next} <  11'(VS_END));
    w_active_next = ({1'b0, w_x_next} < 11'(H_ACTIVE)) &&
                    ({1'b0, w_y_next} < 11'(V_ACTIVE));
    w_tick_next   = (w_x_next == H_LAST) && (w_y_next == V_LAST);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x          <= 10'd0;
      r_y          <= 10'd0;
      r_hsync      <= ~SYNC_POL;
      r_vsync      <= ~SYNC_POL;
      r_active     <= 1'b1;
      r_frame_tick <= 1'b0;
      r_blink      <= 1'b1;
      r_frame_cnt  <= '0;
    end else begin
      r_x          <= w_x_next;
      r_y          <= w_y_next;
      r_hsync      <= w_hs_window ? SYNC_POL : ~SYNC_POL;
      r_vsync      <= w_vs_window ? SYNC_POL : ~SYNC_POL;
      r_active     <= w_active_next;
      r_frame_tick <= w_tick_next;

      // r_frame_tick marks the last pixel; this edge is the wrap to (0,0),
      // which is where the blink output is allowed to change.
      if (r_frame_tick) begin
        if (r_frame_cnt == FC_LAST) begin
          r_frame_cnt <= '0;
          r_blink     <= ~r_blink;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  assign pix_x        = r_x;
  assign pix_y        = r_y;
  assign hsync        = r_hsync;
  assign v_sync       = r_vsync;
  assign video_active = r_active;
  assign frame_tick   = r_frame_tick;
  assign blink_signal = r_blink;

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//
// Three instances share clock and reset:
//   dut_s  : small raster 8/2/2/2 x 4/1/1/1 (14 x 7), BLINK_FRAMES = 3
//   dut_b1 : same raster, BLINK_FRAMES = 1
//   dut_d  : default 640x480 timing (first two lines only)
// A hand-computed vector table is compared against dut_s at fixed cycle
// counts after reset release, a counting model is compared against every
// instance each cycle, and short sequences cover async mid-frame reset,
// frame_tick spacing and blink period.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic [9:0] s_x, s_y, b_x, b_y, d_x, d_y;
  logic s_hs, s_vs, s_va, s_ft, s_bl;
  logic b_hs, b_vs, b_va, b_ft, b_bl;
  logic d_hs, d_vs, d_va, d_ft, d_bl;

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .BLINK_FRAMES(3)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pix_x(s_x), .pix_y(s_y), .hsync(s_hs),
    .v_sync(s_vs), .video_active(s_va), .frame_tick(s_ft), .blink_signal(s_bl)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .BLINK_FRAMES(1)
  ) dut_b1 (
    .clk(clk), .rst_n(rst_n), .pix_x(b_x), .pix_y(b_y), .hsync(b_hs),
    .v_sync(b_vs), .video_active(b_va), .frame_tick(b_ft), .blink_signal(b_bl)
  );

  vga_sync_gen dut_d (
    .clk(clk), .rst_n(rst_n), .pix_x(d_x), .pix_y(d_y), .hsync(d_hs),
    .v_sync(d_vs), .video_active(d_va), .frame_tick(d_ft), .blink_signal(d_bl)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int n);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d actual=%0d required=%0d", nm, n, act, exp);
    end
  endtask

  // Counting model: n clock edges since reset release.
  task automatic model_chk(input string tag, input int n, input int ht, input int vt, input int b,
                           input int ha, input int hs0, input int hs1,
                           input int vact, input int vs0, input int vs1,
                           input logic [9:0] ax, input logic [9:0] ay,
                           input logic ahs, input logic avs, input logic ava,
                           input logic aft, input logic abl);
    int frame_len, p, ex, ey;
    logic ehs, evs, eva, eft, ebl;
    frame_len = ht * vt;
    p   = n % frame_len;
    ex  = p % ht;
    ey  = p / ht;
    ehs = !(ex >= hs0 && ex < hs1);
    evs = !(ey >= vs0 && ey < vs1);
    eva = (ex < ha) && (ey < vact);
    eft = (ex == ht - 1) && (ey == vt - 1);
    ebl = (((n / frame_len) / b) % 2) == 0;
    chk({tag, ".pix_x"}, 32'(ax), 32'(ex), n);
    chk({tag, ".pix_y"}, 32'(ay), 32'(ey), n);
    chk({tag, ".hsync"}, 32'(ahs), 32'(ehs), n);
    chk({tag, ".v_sync"}, 32'(avs), 32'(evs), n);
    chk({tag, ".video_active"}, 32'(ava), 32'(eva), n);
    chk({tag, ".frame_tick"}, 32'(aft), 32'(eft), n);
    chk({tag, ".blink"}, 32'(abl), 32'(ebl), n);
  endtask

  task automatic model_all(input int n);
    model_chk("s", n, 14, 7, 3, 8, 10, 12, 4, 5, 6, s_x, s_y, s_hs, s_vs, s_va, s_ft, s_bl);
    model_chk("b1", n, 14, 7, 1, 8, 10, 12, 4, 5, 6, b_x, b_y, b_hs, b_vs, b_va, b_ft, b_bl);
    if (n < 420000) begin
      model_chk("d", n, 800, 525, 32, 640, 656, 752, 480, 490, 492,
                d_x, d_y, d_hs, d_vs, d_va, d_ft, d_bl);
    end
  endtask

  task automatic reset_chk(input string tag, input logic [9:0] ax, input logic [9:0] ay,
                           input logic ahs, input logic avs, input logic ava,
                           input logic aft, input logic abl);
    chk({tag, ".rst.pix_x"}, 32'(ax), 32'd0, -1);
    chk({tag, ".rst.pix_y"}, 32'(ay), 32'd0, -1);
    chk({tag, ".rst.hsync"}, 32'(ahs), 32'd1, -1);
    chk({tag, ".rst.v_sync"}, 32'(avs), 32'd1, -1);
    chk({tag, ".rst.video_active"}, 32'(ava), 32'd1, -1);
    chk({tag, ".rst.frame_tick"}, 32'(aft), 32'd0, -1);
    chk({tag, ".rst.blink"}, 32'(abl), 32'd1, -1);
  endtask

  task automatic reset_all(input string tag);
    reset_chk({tag, ".s"}, s_x, s_y, s_hs, s_vs, s_va, s_ft, s_bl);
    reset_chk({tag, ".b1"}, b_x, b_y, b_hs, b_vs, b_va, b_ft, b_bl);
    reset_chk({tag, ".d"}, d_x, d_y, d_hs, d_vs, d_va, d_ft, d_bl);
    $display("reset check %s: s=(%0d,%0d) d=(%0d,%0d)", tag, s_x, s_y, d_x, d_y);
  endtask

  typedef struct {
    int         n;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       va;
    logic       ft;
    logic       bl;
  } vec_t;

  localparam int NVEC = 21;
  vec_t tbl [NVEC];

  // Hand-computed expectations for dut_s against cycle count after release.
  task automatic tbl_chk(input int n);
    for (int k = 0; k < NVEC; k++) begin
      if (tbl[k].n == n) begin
        chk("vec.pix_x", 32'(s_x), 32'(tbl[k].x), n);
        chk("vec.pix_y", 32'(s_y), 32'(tbl[k].y), n);
        chk("vec.hsync", 32'(s_hs), 32'(tbl[k].hs), n);
        chk("vec.v_sync", 32'(s_vs), 32'(tbl[k].vs), n);
        chk("vec.video_active", 32'(s_va), 32'(tbl[k].va), n);
        chk("vec.frame_tick", 32'(s_ft), 32'(tbl[k].ft), n);
        chk("vec.blink", 32'(s_bl), 32'(tbl[k].bl), n);
        $display("vec %0d n=%0d x=%0d y=%0d hs=%0b vs=%0b va=%0b ft=%0b bl=%0b",
                 k, n, s_x, s_y, s_hs, s_vs, s_va, s_ft, s_bl);
      end
    end
  endtask

  int last_ft;
  int last_tog;
  int tog_cnt;
  logic prev_bl;

  initial begin
    //              n    x      y      hs  vs  va  ft  bl
    tbl[0]  = '{  0, 10'd0,  10'd0,  1, 1, 1, 0, 1};
    tbl[1]  = '{  1, 10'd1,  10'd0,  1, 1, 1, 0, 1};
    tbl[2]  = '{  7, 10'd7,  10'd0,  1, 1, 1, 0, 1};
    tbl[3]  = '{  8, 10'd8,  10'd0,  1, 1, 0, 0, 1};
    tbl[4]  = '{ 10, 10'd10, 10'd0,  0, 1, 0, 0, 1};
    tbl[5]  = '{ 11, 10'd11, 10'd0,  0, 1, 0, 0, 1};
    tbl[6]  = '{ 12, 10'd12, 10'd0,  1, 1, 0, 0, 1};
    tbl[7]  = '{ 13, 10'd13, 10'd0,  1, 1, 0, 0, 1};
    tbl[8]  = '{ 14, 10'd0,  10'd1,  1, 1, 1, 0, 1};
    tbl[9]  = '{ 56, 10'd0,  10'd4,  1, 1, 0, 0, 1};
    tbl[10] = '{ 66, 10'd10, 10'd4,  0, 1, 0, 0, 1};
    tbl[11] = '{ 70, 10'd0,  10'd5,  1, 0, 0, 0, 1};
    tbl[12] = '{ 80, 10'd10, 10'd5,  0, 0, 0, 0, 1};
    tbl[13] = '{ 83, 10'd13, 10'd5,  1, 0, 0, 0, 1};
    tbl[14] = '{ 84, 10'd0,  10'd6,  1, 1, 0, 0, 1};
    tbl[15] = '{ 97, 10'd13, 10'd6,  1, 1, 0, 1, 1};
    tbl[16] = '{ 98, 10'd0,  10'd0,  1, 1, 1, 0, 1};
    tbl[17] = '{293, 10'd13, 10'd6,  1, 1, 0, 1, 1};
    tbl[18] = '{294, 10'd0,  10'd0,  1, 1, 1, 0, 0};
    tbl[19] = '{587, 10'd13, 10'd6,  1, 1, 0, 1, 0};
    tbl[20] = '{588, 10'd0,  10'd0,  1, 1, 1, 0, 1};

    // Hold reset across a few edges, then check reset values.
    repeat (3) @(negedge clk);
    reset_all("initial");

    // Release on a falling edge: n counts rising edges since release.
    rst_n = 1'b1;
    last_ft = -1;
    for (int n = 0; n < 1700; n++) begin
      if (n > 0) @(negedge clk);
      model_all(n);
      tbl_chk(n);
      if (s_ft) begin
        if (last_ft >= 0) chk("s.frame_tick_gap", 32'(n - last_ft), 32'd98, n);
        last_ft = n;
      end
    end

    // Mid-frame asynchronous reset, between clock edges.
    #2 rst_n = 1'b0;
    #1 reset_all("async");
    @(negedge clk);
    reset_all("held");

    // Second run: blink period restarts from a cleared frame counter.
    rst_n = 1'b1;
    tog_cnt  = 0;
    last_tog = 0;
    prev_bl  = b_bl;
    for (int n = 0; n < 600; n++) begin
      if (n > 0) @(negedge clk);
      model_all(n);
      tbl_chk(n);
      if (b_bl !== prev_bl) begin
        chk("b1.blink_period", 32'(n - last_tog), 32'd98, n);
        last_tog = n;
        tog_cnt++;
      end
      prev_bl = b_bl;
    end
    chk("b1.blink_toggle_count", 32'(tog_cnt), 32'd6, 600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
